// File: rtl/upsample_pkg.sv
// rtl/upsample_pkg.sv - shared types and constants for the 2x stream upsampler
package upsample_pkg;

   typedef enum logic {
      PASS   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   localparam logic DUP_FIRST  = 1'b0;
   localparam logic DUP_SECOND = 1'b1;

   // Counter width that stays legal for a dimension of 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buf_ram.sv
// rtl/line_buf_ram.sv - simple dual-port line buffer with one-cycle registered read
module line_buf_ram #(
   parameter int DEPTH  = 128,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
) (
   input  logic              aclk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/upsample2x_stream.sv
// rtl/upsample2x_stream.sv - 2x nearest-neighbour upsampler for a raster pixel stream
// Optional: define UPSAMPLE_TLAST_CHECK_EN to flag input tlast framing errors on frame_err.
module upsample2x_stream
   import upsample_pkg::*;
#(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int DATA_W = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              frame_err
);

   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);

   state_t            state;
   state_t            state_nxt;
   logic              phase;
   logic              run;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;

   logic              last_col;
   logic              last_row;
   logic              can_load;
   logic              s_hs;
   logic              advance;
   logic              beat_last;
   logic              rd_en;
   logic [COL_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;

   assign last_col = (col == COL_W'(IMG_W - 1));
   assign last_row = (row == ROW_W'(IMG_H - 1));
   assign can_load = !m_axis_tvalid || m_axis_tready;
   assign s_hs     = s_axis_tready && s_axis_tvalid;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= PASS;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (phase == DUP_SECOND && can_load && last_col) begin
         state_nxt = (state == PASS) ? REPLAY : PASS;
      end
   end

   // REPLAY reads one address ahead so rd_data is ready when the next first-copy beat loads.
   always_comb begin
      s_axis_tready = run && (state == PASS) && (phase == DUP_FIRST) && can_load;
      advance       = 1'b0;
      rd_en         = 1'b0;
      rd_addr       = '0;
      beat_last     = (state == REPLAY) && (phase == DUP_SECOND) && last_col && last_row;
      if (phase == DUP_FIRST) begin
         advance = (state == PASS) ? s_hs : can_load;
      end else begin
         advance = can_load;
      end
      if (state == PASS) begin
         rd_en = (phase == DUP_SECOND) && can_load && last_col;
      end else begin
         rd_en   = (phase == DUP_FIRST) && can_load && !last_col;
         rd_addr = col + COL_W'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         run           <= 1'b0;
         phase         <= DUP_FIRST;
         col           <= '0;
         row           <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         run <= 1'b1;
         if (advance) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= beat_last;
            if (phase == DUP_FIRST) begin
               m_axis_tdata <= (state == PASS) ? s_axis_tdata : rd_data;
               phase        <= DUP_SECOND;
            end else begin
               phase <= DUP_FIRST;
               col   <= last_col ? '0 : col + COL_W'(1);
               if (state == REPLAY && last_col) begin
                  row <= last_row ? '0 : row + ROW_W'(1);
               end
            end
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end
      end
   end

   line_buf_ram #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_line_buf (
      .aclk    (aclk),
      .wr_en   (s_hs),
      .wr_addr (col),
      .wr_data (s_axis_tdata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef UPSAMPLE_TLAST_CHECK_EN
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         frame_err <= 1'b0;
      end else if (s_hs && (s_axis_tlast != (last_row && last_col))) begin
         frame_err <= 1'b1;
      end
   end
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_upsample2x_stream.sv
// tb/tb_upsample2x_stream.sv - directed table-driven bench for upsample2x_stream at 4x2
module tb_upsample2x_stream;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int DW = 16;
   localparam int NPIX  = W * H;
   localparam int NBEAT = 4 * NPIX;
`ifdef UPSAMPLE_TLAST_CHECK_EN
   localparam logic CHK_ON = 1'b1;
`else
   localparam logic CHK_ON = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic          frame_err;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   upsample2x_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .frame_err     (frame_err)
   );

   typedef struct {
      logic          do_reset;
      int            pct;
      logic [DW-1:0] base;
      int            bad_idx;
      int            n_in;
      logic          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   // Output beat k of a 4x2 frame: out row k/8, out col k%8, source pixel (orow/2)*4 + ocol/2.
   task automatic run_vec(input vec_t v);
      int            acc = 0;
      int            got = 0;
      int            cyc = 0;
      int            win = 0;
      int            stall = 0;
      int            beats = 0;
      int            idx;
      logic          pv_valid = 1'b0;
      logic          pv_ready = 1'b0;
      logic [DW-1:0] pv_data = '0;
      logic          pv_last = 1'b0;
      logic          s_hs;
      logic          m_hs;
      logic [DW-1:0] exp_data;
      logic          full;
      full = (v.n_in == NPIX);
      while ((acc < v.n_in || (full && got < NBEAT)) && cyc < 600) begin
         @(negedge aclk);
         cyc++;
         m_tready = ($urandom_range(99) < v.pct);
         s_tvalid = (acc < v.n_in);
         s_tdata  = v.base + DW'(acc);
         s_tlast  = (acc == NPIX - 1) ^ (acc == v.bad_idx);
         #1;
         if (pv_valid && !pv_ready) begin
            chk("stall_valid", m_tvalid, 1'b1);
            chk("stall_data", m_tdata, pv_data);
            chk("stall_last", m_tlast, pv_last);
         end
         s_hs = s_tvalid && s_tready;
         m_hs = m_tvalid && m_tready;
         if (m_hs && full) begin
            idx      = ((got / (2 * W)) / 2) * W + (got % (2 * W)) / 2;
            exp_data = v.base + DW'(idx);
            chk($sformatf("beat%0d_data", got), m_tdata, exp_data);
            chk($sformatf("beat%0d_last", got), m_tlast, (got == NBEAT - 1));
         end
         if (m_hs) got++;
         if (win == 1) begin
            if (s_tvalid && !s_tready) stall++;
            if (m_hs) beats++;
            if (s_hs) win = 2;
         end
         if (s_hs && acc == W - 1 && v.pct == 100) win = 1;
         if (s_hs) acc++;
         pv_valid = m_tvalid;
         pv_ready = m_tready;
         pv_data  = m_tdata;
         pv_last  = m_tlast;
      end
      chk("cycle_budget", (cyc >= 600), 1'b0);
      // Input blocked while pixel 4 drains (2 beats) and row 0 replays (8 beats); pixel 5 enters with the last replay beat.
      if (v.pct == 100 && full) begin
         chk("replay_window_closed", win, 2);
         chk("replay_stall_cycles", stall, 9);
         chk("replay_beats", beats, 10);
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      if (full) begin
         @(negedge aclk);
         #1;
         chk("no_residue_valid", m_tvalid, 1'b0);
         chk("idle_ready", s_tready, 1'b1);
         chk("frame_err", frame_err, v.exp_err);
      end
   endtask

   initial begin
      vec_t vecs[7];
      vecs[0] = '{1'b1, 100, 16'h0001, -1, NPIX, 1'b0};
      vecs[1] = '{1'b0, 50, 16'h0001, -1, NPIX, 1'b0};
      vecs[2] = '{1'b0, 40, 16'hA0F0, -1, NPIX, 1'b0};
      vecs[3] = '{1'b0, 100, 16'h0007, -1, 5, 1'b0};
      vecs[4] = '{1'b1, 100, 16'h0001, -1, NPIX, 1'b0};
      vecs[5] = '{1'b0, 100, 16'h0100, 2, NPIX, CHK_ON};
      vecs[6] = '{1'b0, 60, 16'h0200, -1, NPIX, CHK_ON};

      repeat (2) @(negedge aclk);
      #1;
      chk("rst_m_valid", m_tvalid, 1'b0);
      chk("rst_m_last", m_tlast, 1'b0);
      chk("rst_m_data", m_tdata, '0);
      chk("rst_s_ready", s_tready, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_reset) do_reset();
         run_vec(vecs[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
